capture_buffer: RTL and testbench
=================================

# capture_buffer

Triggered acquisition buffer directly downstream of the LVDS/IDDR capture stage. Each `dclk` it takes the 64-bit word of four 16-bit lanes that the capture stage registers and writes it into an on-chip circular RAM while armed. On a trigger, it records the trigger address, stores a programmable number of post-trigger words, then freezes. The RAM is read back through a synchronous read port by the host/readout logic.

## Interface
- `ADDR_W`, 10: RAM address width; depth = 2^ADDR_W 64-bit words.
- `dclk`  in  1  sole clock; same clock the capture stage uses to register `wr_data`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_data`  in  64  capture word, lanes {L3,L2,L1,L0} = bits [63:48]…[15:0]; valid every cycle.
- `arm`  in  1  single-cycle start request.
- `abort`  in  1  single-cycle cancel.
- `ext_trig`  in  1  external trigger, synchronous to `dclk`, rising-edge sensitive.
- `threshold`  in  16  level-trigger threshold (used only with `CAPTURE_LEVEL_TRIG_EN`).
- `cap_len`  in  ADDR_W  post-trigger word count minus one; sampled at trigger.
- `rd_addr`  in  ADDR_W  readback address.
- `rd_data`  out  64  RAM word at `rd_addr`, 1-cycle latency.
- `armed`, `busy`, `done`  out  1 each  status flags.
- `wrapped`  out  1  buffer wrapped at least once since `arm`.
- `trig_addr`  out  ADDR_W  address of the trigger word.
- `start_addr`  out  ADDR_W  address of the oldest valid word.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. `armed` = ARMED. `busy` = ARMED|CAPTURE. `done` = DONE.
- IDLE/DONE + `arm` → ARMED:
  - Clear `wr_ptr`, `wrapped`, `trig_addr`, `start_addr`.
  - Deassert `done`.
- `arm` while busy is ignored.
- ARMED:
  - Write `wr_data` at `wr_ptr` every cycle. `wr_ptr` increments modulo 2^ADDR_W.
  - Set `wrapped` when `wr_ptr` steps from 2^ADDR_W−1 to 0.
- Trigger:
  - `trig` = `ext_trig & ~ext_trig_q` (registered edge detect, `ext_trig_q` resets to 0), OR `level_hit` (see Configuration).
  - Evaluated only in ARMED, against the `wr_data` of that cycle.
- ARMED + `trig`:
  - The current word is written as the trigger word. `trig_addr` ← `wr_ptr`. `post_cnt` ← `cap_len`.
  - If `cap_len` = 0, go to DONE. Otherwise go to CAPTURE.
- CAPTURE:
  - Write every cycle and decrement `post_cnt`.
  - The edge that writes the word with `post_cnt` = 1 goes to DONE. Total words after the trigger word = `cap_len`.
- Entering DONE: `start_addr` ← `wrapped` ? next `wr_ptr` : 0. Writes stop. DONE holds until `arm`.
- `abort` in any state → IDLE next cycle:
  - `done` = 0. RAM contents, `trig_addr` and `wrapped` are kept.
  - Priority: `abort` > `trig` > `arm`. `arm` and `abort` in the same cycle → IDLE.
- `trig` in the same cycle as `arm` is ignored. The first eligible trigger cycle is the first ARMED cycle.
- Readback is allowed in any state. A same-address read during a write returns the old word (read-first).
- Reset (asynchronous, any time including mid-capture):
  - State IDLE.
  - All outputs 0, including `rd_data`.
  - `wr_ptr`, `post_cnt`, `ext_trig_q` = 0.
  - RAM contents are not cleared.

## Timing
- `arm` sampled at edge t: `armed` = 1 from t+1. First write (address 0) at edge t+1.
- Trigger at edge T: trigger word is at `trig_addr`. Last write is at edge T+`cap_len`. `done` = 1 and `busy` = 0 from the cycle after that edge.
- `rd_addr` presented at edge r → `rd_data` valid after edge r+1.
- Status outputs are registered. No combinational paths from inputs to outputs.

## Configuration
- `CAPTURE_LEVEL_TRIG_EN` defined:
  - `level_hit` = 1 when any of the four lanes of `wr_data`, taken as unsigned, is ≥ `threshold`.
  - `level_hit` is combinational on the current word, with no edge qualification.
- Not defined: `level_hit` is tied to 0. `threshold` is present but ignored. Only `ext_trig` triggers.

## Structure
- Package `capture_pkg`:
  - State enum (IDLE/ARMED/CAPTURE/DONE).
  - Constants `LANES` = 4 and `LANE_W` = 16.
  - Function extracting lane i from a 64-bit word.
- Sub-module `capture_ram`: simple dual-port RAM, write port plus registered read-first read port, parameterised by ADDR_W and width 64, with a reset on the output register only.

## Test plan
- Free-running counter on `wr_data`, `arm`, `ext_trig` rise on the 100th ARMED cycle, `cap_len`=15 → `done` after 116 writes; `trig_addr`=100, `wrapped`=0, `start_addr`=0; `rd_addr`=100 returns the counter value of the trigger cycle.
- `cap_len`=511, trigger on the 1500th ARMED cycle → `wrapped`=1, `trig_addr`=476, `start_addr`=988; address 987 holds the last post-trigger word.
- `abort` mid-CAPTURE → IDLE next cycle, `busy`=0, `done`=0. `arm` together with `abort` → stays IDLE.
- `ext_trig` held high from before `arm` → no trigger; drop low then high → trigger on the rise cycle.
- With `CAPTURE_LEVEL_TRIG_EN`, `threshold`=16'h2000:
  - Lane 2 = 16'h1FFF → no trigger.
  - Lane 2 = 16'h2000 → trigger on that word.
  - Without the macro, the same stimulus gives no trigger.
- `rst_n` low mid-CAPTURE → all outputs 0 immediately (asynchronously); after release, `arm`, trigger with `cap_len`=0 → `done` on the cycle after the trigger.

Source files
------------

// File: rtl/capture_buffer_pkg.sv
// capture_buffer_pkg: shared state encoding, lane geometry and lane extraction for the capture buffer
package capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;
  localparam int LANES = 4;
  localparam int LANE_W = 16;
  function automatic logic [LANE_W-1:0] lane(input logic [LANES*LANE_W-1:0] w, input int i);
    return w[i*LANE_W +: LANE_W];
  endfunction
endpackage

// File: rtl/capture_buffer_if.sv
// capture_buffer_if: capture word, control, readback and status bundle of the capture buffer
interface capture_buffer_if #(parameter int ADDR_W = 10);
  logic [63:0]       wr_data;
  logic              arm;
  logic              abort;
  logic              ext_trig;
  logic [15:0]       threshold;
  logic [ADDR_W-1:0] cap_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_data;
  logic              armed;
  logic              busy;
  logic              done;
  logic              wrapped;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  modport master (output wr_data, arm, abort, ext_trig, threshold, cap_len, rd_addr,
                  input rd_data, armed, busy, done, wrapped, trig_addr, start_addr);
  modport slave (input wr_data, arm, abort, ext_trig, threshold, cap_len, rd_addr,
                 output rd_data, armed, busy, done, wrapped, trig_addr, start_addr);
endinterface

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port RAM with a read-first registered read port; only the output register resets
module capture_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  // write port, contents deliberately left uninitialised
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  // read port sees the pre-write word on a same-address collision
  always_comb rd_data_d = mem[ra];
  // output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  assign rd_data = rd_data_q;
endmodule

// File: rtl/capture_buffer.sv
// capture_buffer: triggered circular acquisition buffer; level trigger enabled by CAPTURE_LEVEL_TRIG_EN
module capture_buffer
  import capture_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic dclk,
  input logic rst_n,
  capture_buffer_if.slave bus
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d, start_addr_q, start_addr_d;
  logic wrapped_q, wrapped_d, ext_trig_q, level_hit, trig, we;
`ifdef CAPTURE_LEVEL_TRIG_EN
  // any lane at or above threshold fires on the current word
  always_comb begin
    level_hit = 1'b0;
    for (int i = 0; i < LANES; i++) level_hit |= lane(bus.wr_data, i) >= bus.threshold;
  end
`else
  assign level_hit = 1'b0 & (|bus.threshold);
`endif
  assign trig = (bus.ext_trig & ~ext_trig_q) | level_hit;
  assign we = (state_q == ARMED) || (state_q == CAPTURE);
  // next state, write pointer and capture bookkeeping
  always_comb begin
    state_d = state_q;
    wr_ptr_d = we ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    wrapped_d = wrapped_q | (we & (&wr_ptr_q));
    post_cnt_d = post_cnt_q;
    trig_addr_d = trig_addr_q;
    start_addr_d = start_addr_q;
    if (bus.abort) state_d = IDLE;
    else case (state_q)
      IDLE, DONE: if (bus.arm) begin
        state_d = ARMED;
        wr_ptr_d = '0;
        wrapped_d = 1'b0;
        trig_addr_d = '0;
        start_addr_d = '0;
      end
      ARMED: if (trig) begin
        trig_addr_d = wr_ptr_q;
        post_cnt_d = bus.cap_len;
        state_d = (bus.cap_len == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        post_cnt_d = post_cnt_q - ADDR_W'(1);
        state_d = (post_cnt_q == ADDR_W'(1)) ? DONE : CAPTURE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE && state_q != DONE) start_addr_d = wrapped_d ? wr_ptr_d : '0;
  end
  // state and bookkeeping registers
  always_ff @(posedge dclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      post_cnt_q <= '0;
      trig_addr_q <= '0;
      start_addr_q <= '0;
      wrapped_q <= 1'b0;
      ext_trig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      post_cnt_q <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      start_addr_q <= start_addr_d;
      wrapped_q <= wrapped_d;
      ext_trig_q <= bus.ext_trig;
    end
  capture_ram #(.ADDR_W(ADDR_W), .DATA_W(LANES*LANE_W)) u_ram (
    .clk(dclk), .rst_n(rst_n), .we(we), .wa(wr_ptr_q), .wd(bus.wr_data),
    .ra(bus.rd_addr), .rd_data(bus.rd_data)
  );
  assign bus.armed = state_q == ARMED;
  assign bus.busy = we;
  assign bus.done = state_q == DONE;
  assign bus.wrapped = wrapped_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.start_addr = start_addr_q;
endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: directed self-checking bench for capture_buffer
module tb_capture_buffer;
  logic dclk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] cnt = 64'd0;
  logic free = 1'b1;
  logic [63:0] trig_val, last_val;
  capture_buffer_if #(.ADDR_W(10)) bus();
  capture_buffer #(.ADDR_W(10)) dut (.dclk(dclk), .rst_n(rst_n), .bus(bus));
  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
    cnt = cnt + 64'd1;
    if (free) bus.wr_data = cnt;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.wr_data = 64'd0;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.ext_trig = 1'b0;
    bus.threshold = 16'hFFFF;
    bus.cap_len = 10'd0;
    bus.rd_addr = 10'd0;
    ticks(3);
    chk("rst_armed", {63'd0, bus.armed}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_rd_data", bus.rd_data, 64'd0);
    rst_n = 1'b1;
    // capture with trigger at address 100, 15 post-trigger words
    bus.arm = 1'b1;
    bus.cap_len = 10'd15;
    tick();
    bus.arm = 1'b0;
    chk("t1_armed", {63'd0, bus.armed}, 64'd1);
    ticks(100);
    bus.ext_trig = 1'b1;
    trig_val = bus.wr_data;
    tick();
    bus.ext_trig = 1'b0;
    chk("t1_busy_after_trig", {63'd0, bus.busy}, 64'd1);
    ticks(14);
    chk("t1_not_done_early", {63'd0, bus.done}, 64'd0);
    last_val = bus.wr_data;
    tick();
    chk("t1_done", {63'd0, bus.done}, 64'd1);
    chk("t1_busy", {63'd0, bus.busy}, 64'd0);
    chk("t1_trig_addr", {54'd0, bus.trig_addr}, 64'd100);
    chk("t1_wrapped", {63'd0, bus.wrapped}, 64'd0);
    chk("t1_start_addr", {54'd0, bus.start_addr}, 64'd0);
    bus.rd_addr = 10'd100;
    ticks(2);
    chk("t1_rd_trig_word", bus.rd_data, trig_val);
    bus.rd_addr = 10'd115;
    ticks(2);
    chk("t1_rd_last_word", bus.rd_data, last_val);
    // wrapped capture: trigger at index 1500, 511 post-trigger words
    bus.arm = 1'b1;
    bus.cap_len = 10'd511;
    tick();
    bus.arm = 1'b0;
    chk("t2_done_cleared", {63'd0, bus.done}, 64'd0);
    chk("t2_trig_addr_cleared", {54'd0, bus.trig_addr}, 64'd0);
    ticks(1500);
    chk("t2_wrapped_pre", {63'd0, bus.wrapped}, 64'd1);
    bus.ext_trig = 1'b1;
    tick();
    bus.ext_trig = 1'b0;
    ticks(510);
    last_val = bus.wr_data;
    tick();
    chk("t2_done", {63'd0, bus.done}, 64'd1);
    chk("t2_wrapped", {63'd0, bus.wrapped}, 64'd1);
    chk("t2_trig_addr", {54'd0, bus.trig_addr}, 64'd476);
    chk("t2_start_addr", {54'd0, bus.start_addr}, 64'd988);
    bus.rd_addr = 10'd987;
    ticks(2);
    chk("t2_rd_last_word", bus.rd_data, last_val);
    // abort mid-capture, then arm together with abort
    bus.arm = 1'b1;
    bus.cap_len = 10'd15;
    tick();
    bus.arm = 1'b0;
    ticks(5);
    bus.ext_trig = 1'b1;
    tick();
    bus.ext_trig = 1'b0;
    ticks(3);
    chk("t3_busy_capture", {63'd0, bus.busy}, 64'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t3_abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("t3_abort_done", {63'd0, bus.done}, 64'd0);
    chk("t3_abort_trig_addr", {54'd0, bus.trig_addr}, 64'd5);
    bus.arm = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    chk("t3_arm_abort_idle", {62'd0, bus.armed, bus.busy}, 64'd0);
    // ext_trig held high across arm gives no trigger until a fresh rise
    bus.ext_trig = 1'b1;
    bus.cap_len = 10'd0;
    tick();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    ticks(10);
    chk("t4_held_no_trig", {63'd0, bus.armed}, 64'd1);
    bus.ext_trig = 1'b0;
    tick();
    bus.ext_trig = 1'b1;
    tick();
    bus.ext_trig = 1'b0;
    chk("t4_rise_done", {63'd0, bus.done}, 64'd1);
    chk("t4_rise_trig_addr", {54'd0, bus.trig_addr}, 64'd11);
    // level trigger on lane 2
    free = 1'b0;
    bus.threshold = 16'h2000;
    bus.wr_data = {16'h0000, 16'h1FFF, 16'h0000, 16'h0000};
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    ticks(2);
    chk("t5_below_threshold", {63'd0, bus.armed}, 64'd1);
    bus.wr_data = {16'h0000, 16'h2000, 16'h0000, 16'h0000};
    tick();
`ifdef CAPTURE_LEVEL_TRIG_EN
    chk("t5_level_done", {63'd0, bus.done}, 64'd1);
    chk("t5_level_trig_addr", {54'd0, bus.trig_addr}, 64'd2);
`else
    chk("t5_no_level_trig", {63'd0, bus.armed}, 64'd1);
`endif
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.threshold = 16'hFFFF;
    free = 1'b1;
    // asynchronous reset mid-capture
    bus.rd_addr = 10'd1;
    bus.cap_len = 10'd15;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    ticks(3);
    bus.ext_trig = 1'b1;
    tick();
    bus.ext_trig = 1'b0;
    ticks(2);
    chk("t6_pre_busy", {63'd0, bus.busy}, 64'd1);
    chk("t6_pre_trig_addr", {54'd0, bus.trig_addr}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_status", {60'd0, bus.armed, bus.busy, bus.done, bus.wrapped}, 64'd0);
    chk("t6_rst_trig_addr", {54'd0, bus.trig_addr}, 64'd0);
    chk("t6_rst_start_addr", {54'd0, bus.start_addr}, 64'd0);
    chk("t6_rst_rd_data", bus.rd_data, 64'd0);
    tick();
    rst_n = 1'b1;
    bus.cap_len = 10'd0;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.ext_trig = 1'b1;
    tick();
    bus.ext_trig = 1'b0;
    chk("t6_len0_done", {63'd0, bus.done}, 64'd1);
    chk("t6_len0_busy", {63'd0, bus.busy}, 64'd0);
    chk("t6_len0_trig_addr", {54'd0, bus.trig_addr}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
